corr_scan_sequencer: RTL and testbench
======================================

# corr_scan_sequencer

- Sequences the correlation engine over one saved frame.
- On iFrameDone it walks a coarse grid of candidate (X,Y) start coordinates and, for each one, pulses a start to the engine and waits for its finished strobe.
- It keeps the strictly largest correlation seen and reports its coordinates with a done pulse.
- It sits between the frame-save logic and the correlation datapath; a watchdog aborts the scan if the engine stalls.

## Interface
- H_RES, 640, horizontal search extent; X candidates lie in 0..H_RES-1
- V_RES, 480, vertical search extent; Y candidates lie in 0..V_RES-1
- STEP, 4, coarse grid pitch in pixels, 1..15
- TIMEOUT, 65535, max cycles to wait for iCorrFinished per point, 16-bit counter

Ports:
- iCLK  in  1  clock; all logic rising-edge
- iRST  in  1  reset, asynchronous, active-low
- iFrameDone  in  1  level or pulse; a new scan starts when sampled high in IDLE
- oCorrStart  out  1  one-cycle start pulse to the engine
- oX  out  13  candidate X; stable from oCorrStart until the point completes
- oY  out  13  candidate Y; same stability rule as oX
- iCorrFinished  in  1  one-cycle strobe; iCurrentCorr valid in the same cycle
- iCurrentCorr  in  16  unsigned correlation value
- oXresult  out  13  X of the best point
- oYresult  out  13  Y of the best point
- oBestCorr  out  16  best correlation value
- oBusy  out  1  high from scan start until oDone
- oDone  out  1  one-cycle completion pulse
- oErr  out  1  timeout flag; sticky until the next scan start

## Operation
- Reset values: all outputs 0; FSM in IDLE.
- IDLE: iFrameDone=1 → clear oErr, best-valid flag and counters (X=0, Y=0); set oBusy; go to ISSUE.
- ISSUE: oCorrStart=1 for exactly one cycle; timeout counter cleared; go to WAIT.
- WAIT: counter increments each cycle.
  - iCorrFinished=1 → go to UPDATE with the value registered.
  - Counter reaches TIMEOUT → set oErr and go to DONE; the result registers keep the best of the points completed so far.
- UPDATE: the first point of a scan always loads the best registers.
  - After that, load only if value > oBestCorr (strict); a tie keeps the earlier point.
  - Go to NEXT.
- NEXT (raster order, X fastest):
  - X+STEP ≤ H_RES-1 → X+=STEP.
  - Otherwise X=0; then Y+STEP ≤ V_RES-1 → Y+=STEP.
  - Otherwise the pass is over → REFINE_INIT if enabled, else DONE.
  - More points remain → ISSUE.
- DONE: oDone=1 for one cycle; oBusy=0; go to IDLE.
  - Results hold until the next scan's first UPDATE or a reset.
- Ignored events:
  - iFrameDone outside IDLE.
  - iCorrFinished outside WAIT (no state change).
- Arithmetic: candidate sums are computed at 14 bits before comparison, so there is no wrap at 13 bits.
- Reset mid-scan returns to IDLE immediately with all outputs 0; the engine is not signalled.

## Timing
- From iFrameDone sampled high, oCorrStart rises 2 cycles later (IDLE→ISSUE register, then pulse).
- Per-point overhead beyond engine latency is 3 cycles (ISSUE, UPDATE, NEXT).
- A best update is visible on oXresult/oYresult/oBestCorr one cycle after the UPDATE state.
- oDone is asserted the cycle after the final NEXT or REFINE step.
- After a timeout, oDone is asserted the cycle after the timeout is detected.
- iCorrFinished in the same cycle the counter hits TIMEOUT: the finish wins and there is no error.
- Coarse point count: ceil(H_RES/STEP)·ceil(V_RES/STEP).

## Configuration
- CORR_REFINE_EN defined: after the coarse pass, REFINE_INIT runs a step-1 pass.
  - Window is X in [bx-(STEP-1), bx+(STEP-1)] and Y likewise, around the coarse best (bx,by).
  - Window is clamped to 0..H_RES-1 and 0..V_RES-1.
  - It uses the same ISSUE/WAIT/UPDATE flow, and comparison continues against the coarse best (strict >).
  - The point (bx,by) itself is re-evaluated; under strict > it cannot replace itself.
- CORR_REFINE_EN undefined: DONE follows the coarse pass directly and no refine logic is built.

## Test plan
- Bench setup: H_RES=8, V_RES=4, STEP=2; engine model returns iCurrentCorr=X+10·Y after 5 cycles.
  - Expect 8 start pulses in order (0,0),(2,0),(4,0),(6,0),(0,2)…(6,2).
  - Expect oXresult=6, oYresult=2, oBestCorr=26, then a single oDone.
- Tie: all points return 100 → result (0,0), oBestCorr=100.
- Timeout: TIMEOUT=20; engine never answers the third point → oErr=1 and oDone on cycle 20 of WAIT; result is the best of the first two points.
- Spurious strobes:
  - iCorrFinished pulsed in IDLE and in ISSUE → no state change.
  - iFrameDone held high for the whole scan → exactly one scan, then a new scan starts right after DONE.
- Reset: iRST low during the 4th WAIT → all outputs 0 the next edge; a fresh scan after release gives correct results.
- Refine (CORR_REFINE_EN): peak model with max 500 at (5,3) and coarse best at (4,2) → refine window X 3..5, Y 1..3 (clamped); final result (5,3), oBestCorr=500.

Source files
------------

// File: rtl/corr_scan_sequencer.sv
// corr_scan_sequencer
// Walks the correlation engine over a coarse raster of candidate (X,Y) start
// points after a frame has been saved. It keeps the strictly largest
// correlation and reports its coordinates with a one-cycle done pulse. A
// per-point watchdog aborts the scan and raises a sticky error if the engine
// stalls.
// Optional feature macro: CORR_REFINE_EN adds a step-1 refinement pass over a
// clamped window around the coarse best point.
module corr_scan_sequencer #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int STEP    = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFrameDone,
  output logic        oCorrStart,
  output logic [12:0] oX,
  output logic [12:0] oY,
  input  logic        iCorrFinished,
  input  logic [15:0] iCurrentCorr,
  output logic [12:0] oXresult,
  output logic [12:0] oYresult,
  output logic [15:0] oBestCorr,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr
);

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_ISSUE       = 3'd1;
  localparam logic [2:0] ST_WAIT        = 3'd2;
  localparam logic [2:0] ST_UPDATE      = 3'd3;
  localparam logic [2:0] ST_NEXT        = 3'd4;
  localparam logic [2:0] ST_DONE        = 3'd5;
  localparam logic [2:0] ST_REFINE_INIT = 3'd6;

  // Candidate sums are formed at 14 bits so a step past the edge cannot wrap.
  localparam logic [13:0] X_MAX     = 14'(H_RES - 1);
  localparam logic [13:0] Y_MAX     = 14'(V_RES - 1);
  localparam logic [13:0] PITCH     = 14'(STEP);
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

  logic [2:0]  state_r;
  logic [15:0] cnt_r;
  logic [15:0] corr_r;
  logic        best_valid_r;

  logic [13:0] x_pitch_s;
  logic [13:0] y_pitch_s;
  logic [13:0] x_lim_s;
  logic [13:0] y_lim_s;
  logic [12:0] x_first_s;
  logic [13:0] x_cand_s;
  logic [13:0] y_cand_s;
  logic [15:0] cnt_next_s;
  logic        load_best_s;

`ifdef CORR_REFINE_EN
  localparam logic [12:0] REACH13 = 13'(STEP - 1);
  localparam logic [13:0] REACH14 = 14'(STEP - 1);

  logic        refine_r;
  logic [12:0] x_lo_r;
  logic [13:0] x_hi_r;
  logic [13:0] y_hi_r;

  logic [12:0] win_x_lo_s;
  logic [12:0] win_y_lo_s;
  logic [13:0] win_x_hi_s;
  logic [13:0] win_y_hi_s;

  // Refinement window around the coarse best, clamped to the frame edges.
  always_comb begin
    win_x_lo_s = (oXresult >= REACH13) ? (oXresult - REACH13) : 13'd0;
    win_y_lo_s = (oYresult >= REACH13) ? (oYresult - REACH13) : 13'd0;
    win_x_hi_s = (({1'b0, oXresult} + REACH14) > X_MAX) ? X_MAX : ({1'b0, oXresult} + REACH14);
    win_y_hi_s = (({1'b0, oYresult} + REACH14) > Y_MAX) ? Y_MAX : ({1'b0, oYresult} + REACH14);
  end
`endif

  // Stepping parameters of the current pass and the next-point candidate sums.
  always_comb begin
    x_pitch_s = PITCH;
    y_pitch_s = PITCH;
    x_lim_s   = X_MAX;
    y_lim_s   = Y_MAX;
    x_first_s = 13'd0;
`ifdef CORR_REFINE_EN
    if (refine_r) begin
      x_pitch_s = 14'd1;
      y_pitch_s = 14'd1;
      x_lim_s   = x_hi_r;
      y_lim_s   = y_hi_r;
      x_first_s = x_lo_r;
    end else begin
      x_pitch_s = PITCH;
      y_pitch_s = PITCH;
      x_lim_s   = X_MAX;
      y_lim_s   = Y_MAX;
      x_first_s = 13'd0;
    end
`endif
    x_cand_s    = {1'b0, oX} + x_pitch_s;
    y_cand_s    = {1'b0, oY} + y_pitch_s;
    cnt_next_s  = cnt_r + 16'd1;
    // First point of a scan always loads; afterwards only a strictly larger value.
    load_best_s = (!best_valid_r) || (corr_r > oBestCorr);
  end

  // Scan FSM with candidate coordinates, watchdog and best-result registers.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 16'd0;
      corr_r       <= 16'd0;
      best_valid_r <= 1'b0;
      oCorrStart   <= 1'b0;
      oX           <= 13'd0;
      oY           <= 13'd0;
      oXresult     <= 13'd0;
      oYresult     <= 13'd0;
      oBestCorr    <= 16'd0;
      oBusy        <= 1'b0;
      oDone        <= 1'b0;
      oErr         <= 1'b0;
`ifdef CORR_REFINE_EN
      refine_r     <= 1'b0;
      x_lo_r       <= 13'd0;
      x_hi_r       <= 14'd0;
      y_hi_r       <= 14'd0;
`endif
    end else begin
      oCorrStart <= 1'b0;
      oDone      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (iFrameDone) begin
            oErr         <= 1'b0;
            best_valid_r <= 1'b0;
            oX           <= 13'd0;
            oY           <= 13'd0;
            oBusy        <= 1'b1;
`ifdef CORR_REFINE_EN
            refine_r     <= 1'b0;
`endif
            state_r      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          oCorrStart <= 1'b1;
          cnt_r      <= 16'd0;
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_r <= cnt_next_s;
          // A finish in the same cycle as the watchdog limit takes priority.
          if (iCorrFinished) begin
            corr_r  <= iCurrentCorr;
            state_r <= ST_UPDATE;
          end else if (cnt_next_s == TMO_LIMIT) begin
            oErr    <= 1'b1;
            oBusy   <= 1'b0;
            oDone   <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_UPDATE: begin
          if (load_best_s) begin
            oXresult  <= oX;
            oYresult  <= oY;
            oBestCorr <= corr_r;
          end
          best_valid_r <= 1'b1;
          state_r      <= ST_NEXT;
        end
        ST_NEXT: begin
          if (x_cand_s <= x_lim_s) begin
            oX      <= x_cand_s[12:0];
            state_r <= ST_ISSUE;
          end else begin
            oX <= x_first_s;
            if (y_cand_s <= y_lim_s) begin
              oY      <= y_cand_s[12:0];
              state_r <= ST_ISSUE;
            end else begin
`ifdef CORR_REFINE_EN
              if (!refine_r) begin
                state_r <= ST_REFINE_INIT;
              end else begin
                oBusy   <= 1'b0;
                oDone   <= 1'b1;
                state_r <= ST_DONE;
              end
`else
              oBusy   <= 1'b0;
              oDone   <= 1'b1;
              state_r <= ST_DONE;
`endif
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
`ifdef CORR_REFINE_EN
        ST_REFINE_INIT: begin
          refine_r <= 1'b1;
          x_lo_r   <= win_x_lo_s;
          x_hi_r   <= win_x_hi_s;
          y_hi_r   <= win_y_hi_s;
          oX       <= win_x_lo_s;
          oY       <= win_y_lo_s;
          state_r  <= ST_ISSUE;
        end
`endif
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_corr_scan_sequencer.sv
// Directed testbench for corr_scan_sequencer on an 8x4 frame with STEP=2 and
// TIMEOUT=20. A behavioural engine answers each start pulse after 5 cycles.
module tb_corr_scan_sequencer;

  localparam int H_RES   = 8;
  localparam int V_RES   = 4;
  localparam int STEP    = 2;
  localparam int TIMEOUT = 20;

`ifdef CORR_REFINE_EN
  localparam int RASTER_N  = 17;
  localparam int RASTER_BX = 7;
  localparam int RASTER_BY = 3;
  localparam int RASTER_BC = 37;
  localparam int TIE_N     = 12;
`else
  localparam int RASTER_N  = 8;
  localparam int RASTER_BX = 6;
  localparam int RASTER_BY = 2;
  localparam int RASTER_BC = 26;
  localparam int TIE_N     = 8;
`endif

  logic        clk;
  logic        rst_n;
  logic        frame_done;
  logic        eng_fin;
  logic        spur_fin;
  logic        corr_finished;
  logic [15:0] cur_corr;
  logic        start;
  logic [12:0] ox;
  logic [12:0] oy;
  logic [12:0] xres;
  logic [12:0] yres;
  logic [15:0] best;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_starts = 0;
  int start_cyc = 0;
  int mode = 0;
  int stall_base = 0;
  int log_x [256];
  int log_y [256];

  assign corr_finished = eng_fin | spur_fin;

  corr_scan_sequencer #(
    .H_RES(H_RES), .V_RES(V_RES), .STEP(STEP), .TIMEOUT(TIMEOUT)
  ) dut (
    .iCLK(clk), .iRST(rst_n), .iFrameDone(frame_done),
    .oCorrStart(start), .oX(ox), .oY(oy),
    .iCorrFinished(corr_finished), .iCurrentCorr(cur_corr),
    .oXresult(xres), .oYresult(yres), .oBestCorr(best),
    .oBusy(busy), .oDone(done), .oErr(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine models: 0 = X+10Y, 1 = constant 100, 2 = peak 500 at (5,3),
  // 3 = X+10Y but the third start of the scan is never answered.
  function automatic logic [15:0] model(input int m, input int x, input int y);
    int dx;
    int dy;
    dx = (x > 5) ? (x - 5) : (5 - x);
    dy = (y > 3) ? (y - 3) : (3 - y);
    case (m)
      1:       model = 16'd100;
      2:       model = 16'(500 - 10 * (dx + dy));
      default: model = 16'(x + 10 * y);
    endcase
  endfunction

  // Behavioural correlation engine: logs each start and answers 5 cycles later.
  initial begin : engine
    int px;
    int py;
    eng_fin  = 1'b0;
    cur_corr = 16'd0;
    forever begin
      @(negedge clk);
      if (start === 1'b1) begin
        px = int'(ox);
        py = int'(oy);
        log_x[n_starts % 256] = px;
        log_y[n_starts % 256] = py;
        n_starts  = n_starts + 1;
        start_cyc = cyc;
        if (!(mode == 3 && (n_starts - stall_base) == 3)) begin
          repeat (4) @(negedge clk);
          cur_corr = model(mode, px, py);
          eng_fin  = 1'b1;
          @(negedge clk);
          eng_fin  = 1'b0;
        end
      end
    end
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "global timeout");
  end

  task automatic pulse_frame();
    @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int done_at, output bit timed_out);
    int i;
    timed_out = 1'b1;
    done_at   = 0;
    i         = 0;
    while (timed_out && i < limit) begin
      @(negedge clk);
      if (done === 1'b1) begin
        timed_out = 1'b0;
        done_at   = cyc;
      end
      i++;
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    frame_done = 1'b0;
    spur_fin   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({start, busy, done, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: start/busy/done/err=%b required 0000", {start, busy, done, err});
    end
    checks++;
    if (ox !== 13'd0 || oy !== 13'd0) begin
      errors++;
      $display("FAIL reset_xy: got (%0d,%0d) required (0,0)", ox, oy);
    end
    checks++;
    if (xres !== 13'd0 || yres !== 13'd0 || best !== 16'd0) begin
      errors++;
      $display("FAIL reset_result: got (%0d,%0d,%0d) required (0,0,0)", xres, yres, best);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_raster();
    int  base;
    int  done_at;
    int  extra;
    bit  to;
    mode = 0;
    base = n_starts;
    pulse_frame();
    checks++;
    if (start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL raster_issue: start=%0b busy=%0b required start=0 busy=1", start, busy);
    end
    @(negedge clk);
    checks++;
    if (start !== 1'b1 || ox !== 13'd0 || oy !== 13'd0) begin
      errors++;
      $display("FAIL raster_first_start: start=%0b at (%0d,%0d) required 1 at (0,0)", start, ox, oy);
    end
    wait_done(1000, done_at, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL raster_done_timeout: no oDone within 1000 cycles");
    end
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL raster_done_flags: busy=%0b err=%0b required 0 0", busy, err);
    end
    checks++;
    if ((n_starts - base) !== RASTER_N) begin
      errors++;
      $display("FAIL raster_start_count: got %0d required %0d", n_starts - base, RASTER_N);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (log_x[(base + i) % 256] !== (i % 4) * STEP || log_y[(base + i) % 256] !== (i / 4) * STEP) begin
        errors++;
        $display("FAIL raster_order[%0d]: got (%0d,%0d) required (%0d,%0d)", i,
                 log_x[(base + i) % 256], log_y[(base + i) % 256], (i % 4) * STEP, (i / 4) * STEP);
      end
    end
    checks++;
    if (xres !== 13'(RASTER_BX) || yres !== 13'(RASTER_BY) || best !== 16'(RASTER_BC)) begin
      errors++;
      $display("FAIL raster_result: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
               xres, yres, best, RASTER_BX, RASTER_BY, RASTER_BC);
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL raster_single_done: %0d extra oDone pulses, required 0", extra);
    end
  endtask

  task automatic test_tie();
    int base;
    int done_at;
    bit to;
    mode = 1;
    base = n_starts;
    pulse_frame();
    wait_done(1000, done_at, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL tie_done_timeout: no oDone within 1000 cycles");
    end
    checks++;
    if (xres !== 13'd0 || yres !== 13'd0 || best !== 16'd100) begin
      errors++;
      $display("FAIL tie_result: got (%0d,%0d,%0d) required (0,0,100)", xres, yres, best);
    end
    checks++;
    if ((n_starts - base) !== TIE_N) begin
      errors++;
      $display("FAIL tie_start_count: got %0d required %0d", n_starts - base, TIE_N);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    int base;
    int done_at;
    bit to;
    base       = n_starts;
    stall_base = n_starts;
    mode       = 3;
    pulse_frame();
    wait_done(1000, done_at, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL timeout_done_timeout: no oDone within 1000 cycles");
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flags: err=%0b busy=%0b required 1 0", err, busy);
    end
    checks++;
    if ((done_at - start_cyc) !== TIMEOUT) begin
      errors++;
      $display("FAIL timeout_latency: oDone %0d cycles after start, required %0d", done_at - start_cyc, TIMEOUT);
    end
    checks++;
    if ((n_starts - base) !== 3) begin
      errors++;
      $display("FAIL timeout_start_count: got %0d required 3", n_starts - base);
    end
    checks++;
    if (xres !== 13'd2 || yres !== 13'd0 || best !== 16'd2) begin
      errors++;
      $display("FAIL timeout_result: got (%0d,%0d,%0d) required (2,0,2)", xres, yres, best);
    end
    mode = 0;
    repeat (10) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: err=%0b required 1", err);
    end
  endtask

  task automatic test_spurious();
    int base;
    int done_at;
    bit to;
    mode = 0;
    @(negedge clk);
    spur_fin = 1'b1;
    @(negedge clk);
    spur_fin = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || start !== 1'b0 || xres !== 13'd2 || best !== 16'd2 || err !== 1'b1) begin
      errors++;
      $display("FAIL spurious_idle: busy=%0b start=%0b result=(%0d,%0d) err=%0b required 0 0 (2,2) 1",
               busy, start, xres, best, err);
    end
    base = n_starts;
    @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    spur_fin   = 1'b1;
    @(negedge clk);
    spur_fin   = 1'b0;
    checks++;
    if (start !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL spurious_issue: start=%0b err=%0b required 1 0", start, err);
    end
    wait_done(1000, done_at, to);
    checks++;
    if (to || xres !== 13'(RASTER_BX) || yres !== 13'(RASTER_BY) || best !== 16'(RASTER_BC)) begin
      errors++;
      $display("FAIL spurious_result: timed_out=%0b got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
               to, xres, yres, best, RASTER_BX, RASTER_BY, RASTER_BC);
    end
    checks++;
    if ((n_starts - base) !== RASTER_N) begin
      errors++;
      $display("FAIL spurious_start_count: got %0d required %0d", n_starts - base, RASTER_N);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_held_frame();
    int base;
    int done_at;
    bit to;
    mode = 0;
    base = n_starts;
    @(negedge clk);
    frame_done = 1'b1;
    wait_done(1000, done_at, to);
    checks++;
    if (to || (n_starts - base) !== RASTER_N) begin
      errors++;
      $display("FAIL held_first_scan: timed_out=%0b starts=%0d required %0d", to, n_starts - base, RASTER_N);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL held_idle_gap: busy=%0b required 0", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL held_restart: busy=%0b required 1", busy);
    end
    frame_done = 1'b0;
    wait_done(1000, done_at, to);
    checks++;
    if (to || (n_starts - base) !== 2 * RASTER_N) begin
      errors++;
      $display("FAIL held_second_scan: timed_out=%0b starts=%0d required %0d", to, n_starts - base, 2 * RASTER_N);
    end
    checks++;
    if (xres !== 13'(RASTER_BX) || yres !== 13'(RASTER_BY) || best !== 16'(RASTER_BC)) begin
      errors++;
      $display("FAIL held_result: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
               xres, yres, best, RASTER_BX, RASTER_BY, RASTER_BC);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_scan();
    int base;
    int done_at;
    int i;
    bit to;
    mode = 0;
    base = n_starts;
    pulse_frame();
    i = 0;
    while ((n_starts - base) < 4 && i < 500) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if ((n_starts - base) < 4) begin
      errors++;
      $display("FAIL midreset_reach: only %0d starts seen, required 4", n_starts - base);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({start, busy, done, err} !== 4'b0000 || ox !== 13'd0 || oy !== 13'd0) begin
      errors++;
      $display("FAIL midreset_ctrl: flags=%b xy=(%0d,%0d) required 0000 (0,0)", {start, busy, done, err}, ox, oy);
    end
    checks++;
    if (xres !== 13'd0 || yres !== 13'd0 || best !== 16'd0) begin
      errors++;
      $display("FAIL midreset_result: got (%0d,%0d,%0d) required (0,0,0)", xres, yres, best);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || best !== 16'd0) begin
      errors++;
      $display("FAIL midreset_idle: busy=%0b best=%0d required 0 0", busy, best);
    end
    base = n_starts;
    pulse_frame();
    wait_done(1000, done_at, to);
    checks++;
    if (to || (n_starts - base) !== RASTER_N) begin
      errors++;
      $display("FAIL midreset_rescan: timed_out=%0b starts=%0d required %0d", to, n_starts - base, RASTER_N);
    end
    checks++;
    if (xres !== 13'(RASTER_BX) || yres !== 13'(RASTER_BY) || best !== 16'(RASTER_BC)) begin
      errors++;
      $display("FAIL midreset_result_after: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
               xres, yres, best, RASTER_BX, RASTER_BY, RASTER_BC);
    end
    repeat (3) @(negedge clk);
  endtask

`ifdef CORR_REFINE_EN
  task automatic test_refine();
    int base;
    int done_at;
    bit to;
    mode = 2;
    base = n_starts;
    pulse_frame();
    wait_done(1000, done_at, to);
    checks++;
    if (to || (n_starts - base) !== 17) begin
      errors++;
      $display("FAIL refine_start_count: timed_out=%0b starts=%0d required 17", to, n_starts - base);
    end
    checks++;
    if (log_x[(base + 8) % 256] !== 3 || log_y[(base + 8) % 256] !== 1) begin
      errors++;
      $display("FAIL refine_window_origin: got (%0d,%0d) required (3,1)",
               log_x[(base + 8) % 256], log_y[(base + 8) % 256]);
    end
    checks++;
    if (xres !== 13'd5 || yres !== 13'd3 || best !== 16'd500) begin
      errors++;
      $display("FAIL refine_result: got (%0d,%0d,%0d) required (5,3,500)", xres, yres, best);
    end
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    frame_done = 1'b0;
    spur_fin   = 1'b0;
    test_reset();
    test_raster();
    test_tie();
    test_timeout();
    test_spurious();
    test_held_frame();
    test_reset_mid_scan();
`ifdef CORR_REFINE_EN
    test_refine();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
